// File: rtl/spi_bridge_sequencer.sv
// spi_bridge_sequencer: turns the bootloader's UART byte stream into SPI
// flash transactions (enable/sync, N-out/M-in transfer, boot).
// Optional inter-byte timeout: define SPI_BRIDGE_TIMEOUT_EN.
module spi_bridge_sequencer #(
   parameter int          LEN_W          = 16,
   parameter logic [7:0]  SYNC_BYTE      = 8'hBC,
   parameter logic [7:0]  CMD_BOOT       = 8'h00,
   parameter logic [7:0]  CMD_XFER       = 8'h01,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd120000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_break,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       spi_start,
   output logic [7:0] spi_wdata,
   input  logic       spi_busy,
   input  logic       spi_done,
   input  logic [7:0] spi_rdata,
   output logic       spi_cs_n,
   output logic       boot,
   output logic       enabled
);

   typedef enum logic [3:0] {
      S_DISABLED, S_WAIT_SYNC, S_IDLE,
      S_LEN0, S_LEN1, S_LEN2, S_LEN3,
      S_TX_WAIT, S_TX_SHIFT,
      S_RX_SHIFT, S_RX_WAIT_SPI, S_RX_SEND,
      S_END, S_HALT
   } state_t;

   state_t           state, state_nx;
   logic [LEN_W-1:0] tx_len, rx_len;
   logic [LEN_W-1:0] len_new;    // 16-bit little-endian length being completed
   logic [7:0]       len_lo;
   logic             start_pend; // start requested while the master was busy
   logic             own;        // a byte we launched is in flight
   logic             done_ok;    // spi_done belonging to our own byte
   logic             spi_req;
   logic             abort;
   logic             to_hit;

   assign len_new = LEN_W'({rx_data, len_lo});
   // A byte launched before an abort still completes; its done is not ours.
   assign done_ok = spi_done && own;

`ifdef SPI_BRIDGE_TIMEOUT_EN
   logic [23:0] to_cnt;
   logic        timed;
   assign timed  = state inside {S_LEN0, S_LEN1, S_LEN2, S_LEN3, S_TX_WAIT};
   assign to_hit = timed && !rx_valid && (to_cnt == TIMEOUT_CYCLES);

   // Inter-byte timer: restarts on every byte, only runs while a byte is owed
   always_ff @(posedge clk) begin
      if (rst || rx_valid || !timed) to_cnt <= '0;
      else if (!to_hit)              to_cnt <= to_cnt + 24'd1;
   end
`else
   assign to_hit = 1'b0;
`endif

   assign abort = (rx_break || to_hit) && (state != S_DISABLED) && (state != S_HALT);

   // Next-state decode and SPI byte request
   always_comb begin
      state_nx = state;
      spi_req  = 1'b0;
      if (abort) begin
         state_nx = enabled ? S_IDLE : S_WAIT_SYNC;
      end else begin
         case (state)
            S_DISABLED:    if (rx_break) state_nx = S_WAIT_SYNC;
            S_WAIT_SYNC:   if (rx_valid) state_nx = (rx_data == SYNC_BYTE) ? S_IDLE : S_DISABLED;
            S_IDLE: begin
               if (rx_valid) begin
                  if (rx_data == CMD_XFER)      state_nx = S_LEN0;
                  else if (rx_data == CMD_BOOT) state_nx = S_HALT;
               end
            end
            S_LEN0:        if (rx_valid) state_nx = S_LEN1;
            S_LEN1:        if (rx_valid) state_nx = S_LEN2;
            S_LEN2:        if (rx_valid) state_nx = S_LEN3;
            S_LEN3: begin
               if (rx_valid) begin
                  if (tx_len != '0)       state_nx = S_TX_WAIT;
                  else if (len_new != '0) state_nx = S_RX_SHIFT;
                  else                    state_nx = S_IDLE;
               end
            end
            S_TX_WAIT: begin
               if (rx_valid) begin
                  spi_req  = 1'b1;
                  state_nx = S_TX_SHIFT;
               end
            end
            S_TX_SHIFT: begin
               if (done_ok) begin
                  if (tx_len == LEN_W'(1)) state_nx = (rx_len != '0) ? S_RX_SHIFT : S_END;
                  else                     state_nx = S_TX_WAIT;
               end
            end
            S_RX_SHIFT: begin
               spi_req  = 1'b1;
               state_nx = S_RX_WAIT_SPI;
            end
            S_RX_WAIT_SPI: if (done_ok) state_nx = S_RX_SEND;
            S_RX_SEND: begin
               if (tx_valid && tx_ready) state_nx = (rx_len == LEN_W'(1)) ? S_END : S_RX_SHIFT;
            end
            S_END:         state_nx = S_IDLE;
            S_HALT:        state_nx = S_HALT;
            default:       state_nx = S_DISABLED;
         endcase
      end
   end

   // State register, counters and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_DISABLED;
         tx_len     <= '0;
         rx_len     <= '0;
         len_lo     <= '0;
         start_pend <= 1'b0;
         own        <= 1'b0;
         tx_data    <= '0;
         tx_valid   <= 1'b0;
         spi_start  <= 1'b0;
         spi_wdata  <= '0;
         spi_cs_n   <= 1'b1;
         boot       <= 1'b0;
         enabled    <= 1'b0;
      end else begin
         state     <= state_nx;
         spi_start <= 1'b0;
         boot      <= 1'b0;
         if (done_ok) own <= 1'b0;
         if (abort) begin
            spi_cs_n   <= 1'b1;
            tx_valid   <= 1'b0;
            tx_len     <= '0;
            rx_len     <= '0;
            start_pend <= 1'b0;
            own        <= 1'b0;
         end else begin
            // Launch only into an idle master; otherwise hold the request
            if (spi_req || start_pend) begin
               if (!spi_busy) begin
                  spi_start  <= 1'b1;
                  own        <= 1'b1;
                  start_pend <= 1'b0;
               end else begin
                  start_pend <= 1'b1;
               end
            end
            case (state)
               S_WAIT_SYNC: if (rx_valid && rx_data == SYNC_BYTE) enabled <= 1'b1;
               S_IDLE:      if (rx_valid && rx_data != CMD_XFER && rx_data == CMD_BOOT) boot <= 1'b1;
               S_LEN0:      if (rx_valid) len_lo <= rx_data;
               S_LEN1:      if (rx_valid) tx_len <= len_new;
               S_LEN2:      if (rx_valid) len_lo <= rx_data;
               S_LEN3:      if (rx_valid) rx_len <= len_new;
               S_TX_WAIT: begin
                  if (rx_valid) begin
                     spi_wdata <= rx_data;
                     spi_cs_n  <= 1'b0;
                  end
               end
               S_TX_SHIFT:  if (done_ok) tx_len <= tx_len - LEN_W'(1);
               S_RX_SHIFT: begin
                  spi_cs_n  <= 1'b0;
                  spi_wdata <= 8'h00;
               end
               S_RX_WAIT_SPI: begin
                  if (done_ok) begin
                     tx_data  <= spi_rdata;
                     tx_valid <= 1'b1;
                  end
               end
               S_RX_SEND: begin
                  if (tx_valid && tx_ready) begin
                     tx_valid <= 1'b0;
                     rx_len   <= rx_len - LEN_W'(1);
                  end
               end
               S_END:       spi_cs_n <= 1'b1;
               S_HALT: begin
                  spi_cs_n <= 1'b1;
                  tx_valid <= 1'b0;
                  enabled  <= 1'b0;
               end
               default: ;
            endcase
         end
      end
   end

endmodule
